// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI4-Lite response codes and FSM state encodings for the SRAM responder
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef logic [1:0] rd_state_t;
    typedef logic [1:0] wr_state_t;

    localparam rd_state_t R_IDLE = 2'd0;
    localparam rd_state_t R_WAIT = 2'd1;
    localparam rd_state_t R_RESP = 2'd2;

    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_WAIT = 2'd1;
    localparam wr_state_t W_RESP = 2'd2;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying response delays
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= SEED;
        end else if (en) begin
            out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
        end
    end

endmodule

// File: rtl/axil_sram_responder.sv
// rtl/axil_sram_responder.sv - AXI4-Lite target over a word SRAM with random response latency
module axil_sram_responder
    import axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    LAT_BITS    = 2,
    parameter bit                    RAND_EN     = 1'b1,
    parameter logic [7:0]            LFSR_SEED   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [7:0]          lfsr;
    logic [LAT_BITS-1:0] delay;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .out   (lfsr)
    );

    assign delay = RAND_EN ? lfsr[LAT_BITS-1:0] : '0;

    // ---------------- read channel ----------------
    rd_state_t             rd_state;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [LAT_BITS-1:0]   rd_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rd_ofs;
    logic                  rd_hit;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_sample;

    // A zero delay answers straight from the handshake, so the live address is decoded in idle.
    assign rd_addr   = (rd_state == R_IDLE) ? araddr : ar_addr_q;
    assign rd_ofs    = rd_addr - BASE_ADDR;
    assign rd_hit    = (rd_addr >= BASE_ADDR) && (rd_ofs < SPAN);
    assign rd_idx    = rd_ofs[IDX_W+1:2];
    assign rd_sample = ((rd_state == R_IDLE) && arvalid && (delay == '0)) ||
                       ((rd_state == R_WAIT) && (rd_cnt == '0));

    assign arready = (rd_state == R_IDLE);
    assign rvalid  = (rd_state == R_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= R_IDLE;
            ar_addr_q <= '0;
            rd_cnt    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arvalid) begin
                        ar_addr_q <= araddr;
                        if (delay == '0) begin
                            rd_state <= R_RESP;
                        end else begin
                            rd_cnt   <= delay - 1'b1;
                            rd_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (rd_cnt == '0) rd_state <= R_RESP;
                    else              rd_cnt   <= rd_cnt - 1'b1;
                end
                R_RESP: begin
                    if (rready) rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            rresp <= OKAY;
        end else if (rd_sample) begin
            rdata <= rd_hit ? mem[rd_idx] : '0;
            rresp <= rd_hit ? OKAY : DECERR;
        end
    end

    // ---------------- write channel ----------------
    wr_state_t             wr_state;
    logic                  aw_got;
    logic                  w_got;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [LAT_BITS-1:0]   wr_cnt;
    logic                  aw_take;
    logic                  w_take;
    logic                  wr_both;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [ADDR_WIDTH-1:0] wr_ofs;
    logic                  wr_hit;
    logic [IDX_W-1:0]      wr_idx;

    assign awready = (wr_state == W_IDLE) && !aw_got;
    assign wready  = (wr_state == W_IDLE) && !w_got;
    assign bvalid  = (wr_state == W_RESP);

    assign aw_take   = awready && awvalid;
    assign w_take    = wready && wvalid;
    assign wr_both   = (wr_state == W_IDLE) && (aw_got || aw_take) && (w_got || w_take);
    assign wr_commit = (wr_both && (delay == '0)) ||
                       ((wr_state == W_WAIT) && (wr_cnt == '0));

    // Whichever half arrives on the completing cycle is taken from the bus, the other from its latch.
    assign wr_addr = aw_got ? aw_addr_q : awaddr;
    assign wr_data = w_got  ? w_data_q  : wdata;
    assign wr_strb = w_got  ? w_strb_q  : wstrb;
    assign wr_ofs  = wr_addr - BASE_ADDR;
    assign wr_hit  = (wr_addr >= BASE_ADDR) && (wr_ofs < SPAN);
    assign wr_idx  = wr_ofs[IDX_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= W_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            wr_cnt    <= '0;
            bresp     <= OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_take) begin
                        aw_got    <= 1'b1;
                        aw_addr_q <= awaddr;
                    end
                    if (w_take) begin
                        w_got    <= 1'b1;
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                    end
                    if (wr_both) begin
                        if (delay == '0) begin
                            wr_state <= W_RESP;
                        end else begin
                            wr_cnt   <= delay - 1'b1;
                            wr_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (wr_cnt == '0) wr_state <= W_RESP;
                    else              wr_cnt   <= wr_cnt - 1'b1;
                end
                W_RESP: begin
                    if (bready) begin
                        wr_state <= W_IDLE;
                        aw_got   <= 1'b0;
                        w_got    <= 1'b0;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
            if (wr_commit) bresp <= wr_hit ? OKAY : DECERR;
        end
    end

    // The array itself is left unreset; commit is gated by FSM state, which reset clears.
    always_ff @(posedge clk) begin
        if (wr_commit && wr_hit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lfsr, rd_ofs, wr_ofs};

endmodule

// File: tb/tb_axil_sram_responder.sv
// tb/tb_axil_sram_responder.sv - scoreboard bench for axil_sram_responder
module tb_axil_sram_responder;
    import axil_pkg::*;

    logic clk, rst_n;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0] rresp, bresp;
    logic [3:0] wstrb;

    logic [31:0] araddr0, rdata0, awaddr0, wdata0;
    logic arvalid0, arready0, rvalid0, rready0, awvalid0, awready0, wvalid0, wready0, bvalid0, bready0;
    logic [1:0] rresp0, bresp0;
    logic [3:0] wstrb0;

    axil_sram_responder u_dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axil_sram_responder #(.RAND_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr0), .arvalid(arvalid0), .arready(arready0),
        .rdata(rdata0), .rresp(rresp0), .rvalid(rvalid0), .rready(rready0),
        .awaddr(awaddr0), .awvalid(awvalid0), .awready(awready0),
        .wdata(wdata0), .wstrb(wstrb0), .wvalid(wvalid0), .wready(wready0),
        .bresp(bresp0), .bvalid(bvalid0), .bready(bready0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic [33:0] rq[$];
    logic [1:0]  bq[$];
    logic [33:0] r_exp;
    logic [1:0]  b_exp;
    logic [3:0]  dcov = 4'h0;
    logic [7:0]  mlfsr;
    logic [31:0] model [16];
    logic [31:0] oor_tab [4] = '{32'h7FFF_FFFC, 32'h8000_1000, 32'hFFFF_FFFC, 32'h0000_0000};

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    endfunction

    function automatic void tmo(input string nm);
        n_total++;
        $display("FAIL timeout %s: DUT did not respond within the cycle budget", nm);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // Reference LFSR: x^8+x^6+x^5+x^4, shifting left, stepping every clock out of reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mlfsr <= 8'hA5;
        else        mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
    end

    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) begin
                n_total++;
                $display("FAIL r_unexpected: got rvalid with resp=%h data=%h, expected none", rresp, rdata);
            end else begin
                r_exp = rq.pop_front();
                chk("r_resp_data", {rresp, rdata}, r_exp);
            end
        end
        if (rst_n && bvalid && bready) begin
            if (bq.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected: got bvalid with resp=%h, expected none", bresp);
            end else begin
                b_exp = bq.pop_front();
                chk("b_resp", bresp, b_exp);
            end
        end
    end

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int k;
        rq.push_back({exp_r, exp_d});
        araddr = a; arvalid = 1'b1;
        k = 0; @(negedge clk);
        while (!arready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo("arready");
        @(posedge clk); #1 arvalid = 1'b0;
        k = 0; @(negedge clk);
        while (!rvalid && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) tmo("rvalid");
        else if (k < 4) dcov[k] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_pre, input int w_pre, input logic [1:0] exp_r);
        int k;
        bq.push_back(exp_r);
        fork
            begin
                int ka;
                repeat (aw_pre) begin @(posedge clk); #1; end
                awaddr = a; awvalid = 1'b1;
                ka = 0; @(negedge clk);
                while (!awready && ka < 50) begin @(negedge clk); ka++; end
                if (ka >= 50) tmo("awready");
                @(posedge clk); #1 awvalid = 1'b0;
            end
            begin
                int kw;
                repeat (w_pre) begin @(posedge clk); #1; end
                wdata = d; wstrb = s; wvalid = 1'b1;
                kw = 0; @(negedge clk);
                while (!wready && kw < 50) begin @(negedge clk); kw++; end
                if (kw >= 50) tmo("wready");
                @(posedge clk); #1 wvalid = 1'b0;
            end
        join
        k = 0; @(negedge clk);
        while (!bvalid && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) tmo("bvalid");
        @(posedge clk); #1;
    endtask

    task automatic rd_stall(input logic [31:0] a, input logic [31:0] exp_d);
        int k;
        logic [31:0] held;
        logic stable;
        rq.push_back({OKAY, exp_d});
        rready = 1'b0; araddr = a; arvalid = 1'b1;
        k = 0; @(negedge clk);
        while (!arready && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) tmo("arready_stall");
        @(posedge clk); #1 arvalid = 1'b0;
        k = 0; @(negedge clk);
        while (!rvalid && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) tmo("rvalid_stall");
        held = rdata; stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!rvalid || rdata !== held) stable = 1'b0;
        end
        chk("r_stall_stable", stable, 1);
        @(posedge clk); #1 rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, op, w, w2, lo, ap, wp, hs;
        logic oor, prev, seen_b;
        logic [31:0] a, d, ed;
        logic [3:0] s;

        rst_n = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr0 = '0; arvalid0 = 1'b0; rready0 = 1'b1;
        awaddr0 = '0; awvalid0 = 1'b0; wdata0 = '0; wstrb0 = '0; wvalid0 = 1'b0; bready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_arready0", arready0, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-word write then read back
        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, OKAY);
        rd(32'h8000_0010, 32'hDEAD_BEEF, OKAY);

        // Byte strobes: lanes 0 and 2 replaced
        wr(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, OKAY);
        wr(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 1, 0, OKAY);
        rd(32'h8000_0020, 32'h11BB_33DD, OKAY);

        // Decode boundaries
        rd(32'h7FFF_FFFC, 32'h0, DECERR);
        wr(32'h8000_0000, 32'h0102_0304, 4'hF, 0, 0, OKAY);
        wr(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0, DECERR);
        rd(32'h8000_0000, 32'h0102_0304, OKAY);
        wr(32'h8000_0FFE, 32'h0BAD_CAFE, 4'hF, 0, 2, OKAY);
        rd(32'h8000_0FFC, 32'h0BAD_CAFE, OKAY);

        // W three cycles ahead of AW, concurrent with a read stalled on rready
        fork
            wr(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 3, 0, OKAY);
            rd_stall(32'h8000_0010, 32'hDEAD_BEEF);
        join
        rd(32'h8000_0030, 32'hCAFE_F00D, OKAY);

        // Zero-latency instance: back-to-back reads every other cycle
        araddr0 = 32'h0; arvalid0 = 1'b1; rready0 = 1'b1;
        prev = 1'b0; hs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) chk("tp_rvalid_follows_hs", rvalid0, prev);
            if (rvalid0) chk("tp_rresp", rresp0, DECERR);
            prev = arready0;
            hs += int'(arready0);
        end
        chk("tp_handshakes", hs, 5);
        @(posedge clk); #1 arvalid0 = 1'b0;

        // Reset while a write sits in W_WAIT (bench LFSR picks a delay of 3)
        wr(32'h8000_0040, 32'h55AA_55AA, 4'hF, 0, 0, OKAY);
        k = 0; @(negedge clk);
        while (mlfsr[1:0] != 2'd3 && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) tmo("lfsr_delay3");
        awaddr = 32'h8000_0040; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0; rst_n = 1'b0;
        #1;
        chk("rstmid_bvalid", bvalid, 0);
        chk("rstmid_awready", awready, 1);
        chk("rstmid_wready", wready, 1);
        @(negedge clk); rst_n = 1'b1;
        seen_b = 1'b0;
        repeat (6) begin @(negedge clk); seen_b = seen_b | bvalid; end
        chk("rstmid_no_bresp", seen_b, 0);
        @(posedge clk); #1;
        rd(32'h8000_0040, 32'h55AA_55AA, OKAY);

        // Randomised traffic against the word model
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model[i] = d;
            wr(32'h8000_0400 + 32'(4 * i), d, 4'hF, 0, 0, OKAY);
        end
        for (int i = 0; i < 1000; i++) begin
            op = int'($urandom_range(0, 2));
            w  = int'($urandom_range(0, 15));
            lo = int'($urandom_range(0, 3));
            oor = ($urandom_range(0, 7) == 0);
            a  = oor ? oor_tab[$urandom_range(0, 3)] : 32'h8000_0400 + 32'(4 * w + lo);
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            ap = int'($urandom_range(0, 2));
            wp = int'($urandom_range(0, 2));
            case (op)
                0: begin
                    wr(a, d, s, ap, wp, oor ? DECERR : OKAY);
                    if (!oor) model[w] = merge(model[w], d, s);
                end
                1: rd(a, oor ? 32'h0 : model[w], oor ? DECERR : OKAY);
                default: begin
                    w2 = (w + 1) % 16;
                    ed = oor ? 32'h0 : model[w];
                    fork
                        rd(a, ed, oor ? DECERR : OKAY);
                        wr(32'h8000_0400 + 32'(4 * w2), d, s, ap, wp, OKAY);
                    join
                    model[w2] = merge(model[w2], d, s);
                end
            endcase
        end

        repeat (5) @(negedge clk);
        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);
        chk("delay_cover", dcov, 4'hF);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
